// File: rtl/multibanco_entrada.sv
// Keypad PIN/amount entry controller feeding the Multibanco transaction stage.
// Optional idle-session timeout is built only when MB_TIMEOUT_EN is defined.
module multibanco_entrada #(
   parameter int MAX_TENT = 3,
   parameter int TIMEOUT  = 1000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       CARD,
   input  logic [3:0] KEY,
   input  logic       KEY_VLD,
   input  logic       OK,
   input  logic       CANCEL,
   input  logic [3:0] COD,
   input  logic [3:0] SALDO,
   output logic [3:0] PIN,
   output logic [3:0] VAL,
   output logic       EN,
   output logic       ERRO,
   output logic [1:0] TENT,
   output logic       BLOQ,
   output logic       OCUP
);

   // state     | meaning
   // IDLE      | no card, waiting for insertion
   // PIN_WAIT  | collecting PIN digit, waiting for OK
   // PIN_CHECK | compare latched PIN with card code
   // VAL_WAIT  | collecting amount digit, waiting for OK
   // VAL_CHECK | compare amount with balance
   // ISSUE     | EN strobe to transaction stage
   // DONE      | transaction issued, waiting for card removal
   // BLOCKED   | attempts exhausted, only reset exits
   typedef enum logic [2:0] {
      IDLE, PIN_WAIT, PIN_CHECK, VAL_WAIT, VAL_CHECK, ISSUE, DONE, BLOCKED
   } state_t;

   localparam logic [1:0] TENT_MAX = 2'(MAX_TENT);

   if (MAX_TENT < 1 || MAX_TENT > 3 || TIMEOUT < 1) begin : g_bad_param
      $error("multibanco_entrada: MAX_TENT must be 1..3 and TIMEOUT >= 1");
   end

   state_t     state_q, state_d;
   logic [3:0] pin_q, pin_d;
   logic [3:0] val_q, val_d;
   logic [1:0] tent_q, tent_d;
   logic       seen_q, seen_d;
   logic       en_q, en_d;
   logic       erro_q, erro_d;
   logic       bloq_q, bloq_d;
   logic       ocup_q, ocup_d;
   logic       in_wait;
   logic       abortable;
   logic       timeout;

   assign in_wait   = (state_q == PIN_WAIT) || (state_q == VAL_WAIT);
   assign abortable = in_wait || (state_q == PIN_CHECK) || (state_q == VAL_CHECK);

`ifdef MB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wait_next;

   assign wait_next = (state_d == PIN_WAIT) || (state_d == VAL_WAIT);
   assign timeout   = in_wait && (cnt_q == '0);

   // Down-counter reloads on entry to a wait state and on any key/OK activity.
   always_comb begin
      cnt_d = cnt_q;
      if (wait_next && ((state_d != state_q) || KEY_VLD || OK))
         cnt_d = CW'(TIMEOUT);
      else if (in_wait && (cnt_q != '0))
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) cnt_q <= CW'(TIMEOUT);
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pin_d   = pin_q;
      val_d   = val_q;
      tent_d  = tent_q;
      seen_d  = seen_q;
      erro_d  = 1'b0;
      bloq_d  = bloq_q;

      if (abortable && (CANCEL || !CARD || timeout)) begin
         state_d = IDLE;
         pin_d   = 4'd0;
         val_d   = 4'd0;
         seen_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               seen_d = 1'b0;
               if (CARD) state_d = PIN_WAIT;
            end
            // OK outranks a same-cycle key, so that key is dropped.
            PIN_WAIT: begin
               if (OK) begin
                  if (seen_q) state_d = PIN_CHECK;
               end else if (KEY_VLD) begin
                  pin_d  = KEY;
                  seen_d = 1'b1;
               end
            end
            PIN_CHECK: begin
               seen_d = 1'b0;
               if (pin_q == COD) begin
                  state_d = VAL_WAIT;
                  tent_d  = TENT_MAX;
               end else begin
                  erro_d = 1'b1;
                  tent_d = tent_q - 2'd1;
                  if (tent_q == 2'd1) begin
                     state_d = BLOCKED;
                     bloq_d  = 1'b1;
                  end else begin
                     state_d = PIN_WAIT;
                  end
               end
            end
            VAL_WAIT: begin
               if (OK) begin
                  if (seen_q) state_d = VAL_CHECK;
               end else if (KEY_VLD) begin
                  val_d  = KEY;
                  seen_d = 1'b1;
               end
            end
            VAL_CHECK: begin
               if ((val_q == 4'd0) || (val_q > SALDO)) begin
                  erro_d  = 1'b1;
                  seen_d  = 1'b0;
                  state_d = VAL_WAIT;
               end else begin
                  state_d = ISSUE;
               end
            end
            ISSUE: state_d = DONE;
            DONE: begin
               if (!CARD) state_d = IDLE;
            end
            BLOCKED: begin
               tent_d = 2'd0;
               bloq_d = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Strobe and busy flags are derived from the next state so they line up
   // with the state they describe.
   assign en_d   = (state_d == ISSUE);
   assign ocup_d = (state_d != IDLE);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         pin_q   <= 4'd0;
         val_q   <= 4'd0;
         tent_q  <= TENT_MAX;
         seen_q  <= 1'b0;
         en_q    <= 1'b0;
         erro_q  <= 1'b0;
         bloq_q  <= 1'b0;
         ocup_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pin_q   <= pin_d;
         val_q   <= val_d;
         tent_q  <= tent_d;
         seen_q  <= seen_d;
         en_q    <= en_d;
         erro_q  <= erro_d;
         bloq_q  <= bloq_d;
         ocup_q  <= ocup_d;
      end
   end

   assign PIN  = pin_q;
   assign VAL  = val_q;
   assign EN   = en_q;
   assign ERRO = erro_q;
   assign TENT = tent_q;
   assign BLOQ = bloq_q;
   assign OCUP = ocup_q;

endmodule

// File: doc/multibanco_entrada.md
# multibanco_entrada

Keypad entry controller sitting directly upstream of the Multibanco transaction stage. It collects a 4-bit PIN from the keypad and checks it against the card code, enforcing a limited number of attempts with permanent lockout. It then collects a 4-bit withdrawal value and checks it against the balance. For each validated withdrawal it issues a single-cycle `EN` strobe with stable `PIN`/`VAL` to the transaction stage.

## Interface
- `MAX_TENT`, 3: PIN attempts allowed before lockout (1..3).
- `TIMEOUT`, 1000: idle cycles before an abandoned session is dropped; only used with the timeout feature.

- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  asynchronous active-low reset.
- `CARD`  in  1  card-present level.
- `KEY`  in  4  keypad digit, valid when `KEY_VLD`=1.
- `KEY_VLD`  in  1  one-cycle key strobe.
- `OK`  in  1  one-cycle confirm strobe.
- `CANCEL`  in  1  one-cycle abort strobe.
- `COD`  in  4  card code; sampled in PIN_CHECK.
- `SALDO`  in  4  current balance; sampled in VAL_CHECK.
- `PIN`  out  4  latched PIN.
- `VAL`  out  4  latched withdrawal value.
- `EN`  out  1  one-cycle transaction strobe.
- `ERRO`  out  1  one-cycle rejection strobe.
- `TENT`  out  2  attempts remaining.
- `BLOQ`  out  1  lockout level.
- `OCUP`  out  1  session active (state ≠ IDLE).

## Operation
- States: IDLE, PIN_WAIT, PIN_CHECK, VAL_WAIT, VAL_CHECK, ISSUE, DONE, BLOCKED.
- IDLE: `CARD`=1 → PIN_WAIT. Clear the digit-seen flag.
- PIN_WAIT:
  - `KEY_VLD` overwrites `PIN` with `KEY` and sets the digit-seen flag.
  - `OK` with the flag set → PIN_CHECK. `OK` without a digit is ignored.
- PIN_CHECK (1 cycle):
  - `PIN`==`COD` → VAL_WAIT, `TENT`←`MAX_TENT`, clear the flag.
  - Mismatch → `TENT`−1 and `ERRO` pulse.
  - If the new `TENT`=0 → BLOCKED. Otherwise → PIN_WAIT with the flag cleared.
- VAL_WAIT: `KEY_VLD` overwrites `VAL` and sets the flag. `OK` with the flag set → VAL_CHECK.
- VAL_CHECK (1 cycle):
  - `VAL`=0 or `VAL`>`SALDO` (4-bit unsigned compare) → `ERRO` pulse, back to VAL_WAIT with the flag cleared.
  - Otherwise → ISSUE.
- ISSUE: `EN`=1 for exactly this cycle → DONE.
- DONE: `PIN`/`VAL` held. `CARD`=0 → IDLE. Further keys and `OK` are ignored.
- BLOCKED:
  - `BLOQ`=1, `TENT`=0. All inputs are ignored, including `CARD` and `CANCEL`.
  - Exit only via `RST_N`.
- Abort: `CANCEL`=1 or `CARD`=0 in PIN_WAIT, PIN_CHECK, VAL_WAIT or VAL_CHECK → IDLE.
  - `PIN` and `VAL` are cleared to 0.
  - `TENT` is not restored, so failed attempts persist across card sessions until a correct PIN.
- Simultaneous strobes, priority order: `CANCEL`/`CARD`=0 > `OK` > `KEY_VLD`.
  - A key arriving in the same cycle as `OK` is discarded.
  - The check uses the previously latched digit.
- `EN` and `ERRO` are never asserted together.

## Timing
- All outputs are registered.
- Reset values: `PIN`=0, `VAL`=0, `EN`=0, `ERRO`=0, `TENT`=`MAX_TENT`, `BLOQ`=0, `OCUP`=0. State = IDLE.
- Reset is asynchronous; assertion mid-session returns to IDLE immediately, including from BLOCKED.
- `OK` in cycle n (PIN_WAIT) → PIN_CHECK in cycle n+1:
  - `ERRO` or `TENT` reload visible in n+2.
  - VAL_WAIT entered in n+2.
- `OK` in cycle n (VAL_WAIT) → `EN`=1 in cycle n+2.
  - `PIN` and `VAL` are stable from n+1 through DONE.
- `ERRO` is high for one cycle, n+2, after the rejecting `OK`.
- `BLOQ` rises in the same cycle as the final `ERRO`.
- A key strobe in cycle n is visible on `PIN`/`VAL` in n+1.

## Configuration
- `MB_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT+1)`-bit counter runs in PIN_WAIT and VAL_WAIT.
  - It restarts on any `KEY_VLD` or `OK`, and on entry to either state.
  - Reaching `TIMEOUT` → IDLE with the same effects as `CANCEL`.
  - No `ERRO`, and no `TENT` change.
- Undefined: no counter is built and sessions wait indefinitely.

## Test plan
- `COD`=5, `SALDO`=9, `MAX_TENT`=3:
  - Stimulus: `CARD`=1, key 5, `OK`, key 4, `OK`.
  - Required: `EN` high for 1 cycle exactly 2 cycles after the second `OK`, with `PIN`=5, `VAL`=4, `TENT`=3.
- Three wrong PINs (key 2, `OK`, ×3):
  - Required: `ERRO` pulses three times and `TENT` goes 2, 1, 0.
  - `BLOQ`=1 with the third `ERRO`.
  - Then `CARD`=0 and key 5, `OK` give no state change; `RST_N` pulse clears `BLOQ` and sets `TENT`=3.
- Amount checks, `SALDO`=3:
  - `VAL`=7 then `OK` → `ERRO`, stays in VAL_WAIT, no `EN`.
  - `VAL`=0 then `OK` → `ERRO`.
  - `VAL`=3 then `OK` → `EN`.
- Same-cycle `KEY_VLD`(9) and `OK` after key 5 in PIN_WAIT:
  - Required: the check uses 5 and `PIN` stays 5.
  - Same-cycle `CANCEL` and `OK` → IDLE with `PIN`=0.
- Abort persistence: one wrong PIN, then `CARD`=0, then reinsert.
  - Required: `TENT`=2 persists.
  - Correct PIN reloads `TENT`=3.
- With `MB_TIMEOUT_EN`, `TIMEOUT`=20, and no keys for 20 cycles in PIN_WAIT:
  - Required: `OCUP`→0, no `ERRO`, `TENT` unchanged.
  - Without the macro, the same stimulus stays in PIN_WAIT after 100 cycles.
